// File: rtl/reg_xfer_pkg.sv
// rtl/reg_xfer_pkg.sv - shared op codes, FSM states and register addresses for reg_xfer_ctrl
package reg_xfer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADD  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        RD   = 3'd2,
        CALC = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_e;

    // Address 2'b11 also selects C in the register group.
    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;
    localparam logic [1:0] REG_C = 2'b10;

    // Every op except READ ends with a register write.
    function automatic logic is_write_op(input op_e op);
        return (op != OP_READ);
    endfunction

endpackage

// File: rtl/reg_xfer_alu.sv
// rtl/reg_xfer_alu.sv - combinational LOAD/MOV/ADD/READ result (carry output with REG_XFER_FLAGS_EN)
module reg_xfer_alu
    import reg_xfer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_e               i_op,
    input  logic [DATA_W-1:0] i_s,
    input  logic [DATA_W-1:0] i_d,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result
`ifdef REG_XFER_FLAGS_EN
    ,
    output logic              o_carry
`endif
);

`ifdef REG_XFER_FLAGS_EN
    logic [DATA_W:0] w_sum;

    // Widened add so the carry-out is available for the flag.
    always_comb begin
        w_sum    = {1'b0, i_s} + {1'b0, i_d};
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_LOAD: o_result = i_imm;
            OP_MOV:  o_result = i_s;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_READ: o_result = i_s;
            default: o_result = '0;
        endcase
    end
`else
    // Plain modulo-2^DATA_W add; no carry is kept.
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_LOAD: o_result = i_imm;
            OP_MOV:  o_result = i_s;
            OP_ADD:  o_result = i_s + i_d;
            OP_READ: o_result = i_s;
            default: o_result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - register-transfer initiator for the A/B/C register group (optional REG_XFER_FLAGS_EN)
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              rg_we,
    output logic [ADDR_W-1:0] rg_raa,
    output logic [ADDR_W-1:0] rg_rwba,
    output logic [DATA_W-1:0] rg_i,
    input  logic [DATA_W-1:0] rg_s,
    input  logic [DATA_W-1:0] rg_d
`ifdef REG_XFER_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    state_e            r_state;
    logic              r_ready;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_we;
    logic [ADDR_W-1:0] r_raa;
    logic [ADDR_W-1:0] r_rwba;
    logic [DATA_W-1:0] r_i;
    op_e               r_op;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] r_d;

    op_e               w_alu_op;
    logic [DATA_W-1:0] w_alu_result;

    // LOAD goes straight from IDLE to WR, so in IDLE the ALU sees the
    // incoming op and immediate; afterwards it sees the latched op.
    assign w_alu_op = (r_state == IDLE) ? op_e'(cmd_op) : r_op;

`ifdef REG_XFER_FLAGS_EN
    logic r_flag_z;
    logic r_flag_c;
    logic w_alu_carry;

    reg_xfer_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_alu_op),
        .i_s      (r_s),
        .i_d      (r_d),
        .i_imm    (cmd_imm),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // Flags follow the result: at acceptance for LOAD, at CALC otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if ((r_state == IDLE && r_ready && cmd_valid && w_alu_op == OP_LOAD) ||
                     (r_state == CALC)) begin
            r_flag_z <= (w_alu_result == '0);
            r_flag_c <= w_alu_carry;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;
`else
    reg_xfer_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_alu_op),
        .i_s      (r_s),
        .i_d      (r_d),
        .i_imm    (cmd_imm),
        .o_result (w_alu_result)
    );
`endif

    // Transfer FSM; every group-facing signal is registered so addresses
    // and write data never change near the negedge the group writes on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
            r_we     <= 1'b1;
            r_raa    <= '0;
            r_rwba   <= '0;
            r_i      <= '0;
            r_op     <= OP_LOAD;
            r_src    <= '0;
            r_dst    <= '0;
            r_s      <= '0;
            r_d      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= w_alu_op;
                        r_src   <= cmd_src;
                        r_dst   <= cmd_dst;
                        if (w_alu_op == OP_LOAD) begin
                            r_state  <= WR;
                            r_we     <= 1'b0;
                            r_rwba   <= cmd_dst;
                            r_i      <= w_alu_result;
                            r_result <= w_alu_result;
                        end else begin
                            // Complemented addresses guarantee both read
                            // ports see an address change before RD.
                            r_state <= PRE;
                            r_raa   <= ~cmd_src;
                            r_rwba  <= ~cmd_dst;
                        end
                    end
                end
                PRE: begin
                    r_state <= RD;
                    r_raa   <= r_src;
                    r_rwba  <= r_dst;
                end
                RD: begin
                    r_state <= CALC;
                    r_s     <= rg_s;
                    r_d     <= rg_d;
                end
                CALC: begin
                    r_result <= w_alu_result;
                    if (is_write_op(r_op)) begin
                        r_state <= WR;
                        r_we    <= 1'b0;
                        r_i     <= w_alu_result;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                WR: begin
                    r_state <= DONE;
                    r_we    <= 1'b1;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_we    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign done      = r_done;
    assign result    = r_result;
    assign rg_we     = r_we;
    assign rg_raa    = r_raa;
    assign rg_rwba   = r_rwba;
    assign rg_i      = r_i;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb/tb_reg_xfer_ctrl.sv - self-checking bench for reg_xfer_ctrl with a behavioural A/B/C register group
module tb_reg_xfer_ctrl;
    import reg_xfer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_src = 2'b00;
    logic [1:0] cmd_dst = 2'b00;
    logic [7:0] cmd_imm = 8'h00;
    logic       cmd_ready;
    logic       done;
    logic [7:0] result;
    logic       rg_we;
    logic [1:0] rg_raa;
    logic [1:0] rg_rwba;
    logic [7:0] rg_i;
    logic [7:0] rg_s = 8'h00;
    logic [7:0] rg_d = 8'h00;
`ifdef REG_XFER_FLAGS_EN
    logic       flag_z;
    logic       flag_c;
`endif

    always #5 clk = ~clk;

    reg_xfer_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .done      (done),
        .result    (result),
        .rg_we     (rg_we),
        .rg_raa    (rg_raa),
        .rg_rwba   (rg_rwba),
        .rg_i      (rg_i),
        .rg_s      (rg_s),
        .rg_d      (rg_d)
`ifdef REG_XFER_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_c    (flag_c)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ridx(input logic [1:0] a);
        return a[1] ? 2 : (a[0] ? 1 : 0);
    endfunction

    // Register group: written on negedge while the strobe is low; read ports
    // refresh only when their address changes.
    logic [7:0] g_regs [3] = '{8'h00, 8'h00, 8'h60};
    always @(negedge clk) if (rg_we === 1'b0) g_regs[ridx(rg_rwba)] <= rg_i;
    always @(rg_raa) rg_s = g_regs[ridx(rg_raa)];
    always @(rg_rwba) rg_d = g_regs[ridx(rg_rwba)];

    // Transaction-level model: latency table, expected register file and
    // expected result; compared against the DUT every cycle.
    logic       m_idle = 1'b1;
    int         m_k = 0;
    int         m_n = 0;
    logic [1:0] m_op = 2'b00;
    logic [1:0] m_src = 2'b00;
    logic [1:0] m_dst = 2'b00;
    logic [1:0] m_nsrc;
    logic [1:0] m_ndst;
    logic [7:0] m_exp = 8'h00;
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_rgi = 8'h00;
    logic [7:0] m_regs [3] = '{8'h00, 8'h00, 8'h60};
    logic       exp_done;
`ifdef REG_XFER_FLAGS_EN
    logic       m_cexp = 1'b0;
    logic       m_z = 1'b0;
    logic       m_c = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_k = 0; m_res = 8'h00; m_rgi = 8'h00;
`ifdef REG_XFER_FLAGS_EN
            m_z = 1'b0; m_c = 1'b0;
`endif
        end else if (m_idle) begin
            if (cmd_valid) begin
                m_op = cmd_op; m_src = cmd_src; m_dst = cmd_dst;
                m_idle = 1'b0; m_k = 1;
                case (cmd_op)
                    2'd0: begin m_exp = cmd_imm; m_n = 2; end
                    2'd1: begin m_exp = m_regs[ridx(cmd_src)]; m_n = 5; end
                    2'd2: begin m_exp = m_regs[ridx(cmd_src)] + m_regs[ridx(cmd_dst)]; m_n = 5; end
                    default: begin m_exp = m_regs[ridx(cmd_src)]; m_n = 4; end
                endcase
`ifdef REG_XFER_FLAGS_EN
                m_cexp = (cmd_op == 2'd2) &&
                         ((int'(m_regs[ridx(cmd_src)]) + int'(m_regs[ridx(cmd_dst)])) > 255);
`endif
            end
        end else begin
            if (m_op != 2'd3 && m_k == m_n - 1) m_regs[ridx(m_dst)] = m_exp;
            if (m_k == m_n) m_idle = 1'b1;
            else m_k++;
        end
        if (!m_idle && m_op != 2'd3 && m_k == m_n - 1) m_rgi = m_exp;
        exp_done = !m_idle && (m_k == m_n);
        if (exp_done) begin
            m_res = m_exp;
`ifdef REG_XFER_FLAGS_EN
            m_z = (m_exp == 8'h00); m_c = m_cexp;
`endif
        end
        m_nsrc = ~m_src;
        m_ndst = ~m_dst;
        #1;
        if (!rst_n) begin
            chk("rst_ready", cmd_ready, 1);
            chk("rst_done", done, 0);
            chk("rst_result", result, 0);
            chk("rst_we", rg_we, 1);
            chk("rst_raa", rg_raa, 0);
            chk("rst_rwba", rg_rwba, 0);
            chk("rst_rg_i", rg_i, 0);
        end else begin
            chk("ready", cmd_ready, m_idle);
            chk("done", done, exp_done);
            chk("we", rg_we, !(!m_idle && m_op != 2'd3 && m_k == m_n - 1));
            chk("rg_i", rg_i, m_rgi);
            if (m_idle || exp_done) begin
                chk("result", result, m_res);
`ifdef REG_XFER_FLAGS_EN
                chk("flag_z", flag_z, m_z);
                chk("flag_c", flag_c, m_c);
`endif
            end
            if (!m_idle && m_op == 2'd0 && m_k == 1) chk("wr_addr_load", rg_rwba, m_dst);
            if (!m_idle && m_op != 2'd0) begin
                if (m_k == 1) begin
                    chk("pre_raa", rg_raa, m_nsrc);
                    chk("pre_rwba", rg_rwba, m_ndst);
                end else if (m_k < m_n) begin
                    chk("raa", rg_raa, m_src);
                    chk("rwba", rg_rwba, m_dst);
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                           input logic [7:0] imm, output logic [7:0] res, output int lat, output int nwe);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        guard = 0; nwe = 0; lat = 0; res = 8'h00;
        while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        chk("accept_ready", cmd_ready, 1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        lat = 1; guard = 0;
        forever begin
            if (rg_we === 1'b0) nwe++;
            if (done === 1'b1 || guard >= 20) break;
            @(posedge clk); #2;
            lat++; guard++;
        end
        chk("done_seen", done, 1);
        res = result;
    endtask

    logic [7:0] res;
    int         lat;
    int         nwe;
    int         n_acc;
    int         acc [3];
    logic       rdy;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // READ C before any write
        run_cmd(OP_READ, REG_C, REG_A, 8'h00, res, lat, nwe);
        chk("readC_result", res, 8'h60);
        chk("readC_lat", lat, 4);
        chk("readC_no_we", nwe, 0);

        // 0x12 + 0x34
        run_cmd(OP_LOAD, REG_A, REG_A, 8'h12, res, lat, nwe);
        chk("load_lat", lat, 2);
        chk("load_we_pulses", nwe, 1);
        run_cmd(OP_LOAD, REG_A, REG_B, 8'h34, res, lat, nwe);
        run_cmd(OP_ADD, REG_B, REG_A, 8'h00, res, lat, nwe);
        chk("add_result", res, 8'h46);
        chk("add_lat", lat, 5);
`ifdef REG_XFER_FLAGS_EN
        chk("add_z", flag_z, 0);
        chk("add_c", flag_c, 0);
`endif
        run_cmd(OP_READ, REG_A, REG_B, 8'h00, res, lat, nwe);
        chk("readA_46", res, 8'h46);

        // 0xF0 + 0x20 wraps with carry, then MOV into C
        run_cmd(OP_LOAD, REG_A, REG_A, 8'hF0, res, lat, nwe);
        run_cmd(OP_LOAD, REG_A, REG_B, 8'h20, res, lat, nwe);
        run_cmd(OP_ADD, REG_B, REG_A, 8'h00, res, lat, nwe);
        chk("add_wrap", res, 8'h10);
`ifdef REG_XFER_FLAGS_EN
        chk("add_wrap_c", flag_c, 1);
`endif
        run_cmd(OP_MOV, REG_A, REG_C, 8'h00, res, lat, nwe);
        chk("mov_lat", lat, 5);
        run_cmd(OP_READ, 2'b11, REG_A, 8'h00, res, lat, nwe);
        chk("readC_10", res, 8'h10);

        // three LOADs with cmd_valid held high
        @(negedge clk);
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dst = REG_A; cmd_imm = 8'h11;
        n_acc = 0; nwe = 0; acc[0] = -1; acc[1] = -1; acc[2] = -1;
        for (int i = 0; i < 9; i++) begin
            rdy = cmd_ready;
            @(posedge clk); #2;
            if (rg_we === 1'b0) nwe++;
            if (rdy && cmd_valid && n_acc < 3) begin
                acc[n_acc] = i; n_acc++;
                cmd_imm = cmd_imm + 8'h11; cmd_dst = 2'(n_acc);
                if (n_acc == 3) cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("burst_count", n_acc, 3);
        chk("burst_acc0", acc[0], 0);
        chk("burst_acc1", acc[1], 3);
        chk("burst_acc2", acc[2], 6);
        chk("burst_we", nwe, 3);

        // reset in the WR cycle of a second LOAD to A
        run_cmd(OP_LOAD, REG_A, REG_A, 8'h55, res, lat, nwe);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_dst = REG_A; cmd_imm = 8'hAA;
        while (cmd_ready !== 1'b1) @(negedge clk);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", rg_we, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_cmd(OP_READ, REG_A, REG_A, 8'h00, res, lat, nwe);
        chk("readA_55", res, 8'h55);

        // ADD A,A with A=0x80
        run_cmd(OP_LOAD, REG_A, REG_A, 8'h80, res, lat, nwe);
        run_cmd(OP_ADD, REG_A, REG_A, 8'h00, res, lat, nwe);
        chk("double_80", res, 8'h00);
`ifdef REG_XFER_FLAGS_EN
        chk("double_z", flag_z, 1);
        chk("double_c", flag_c, 1);
`endif
        run_cmd(OP_READ, REG_A, REG_B, 8'h00, res, lat, nwe);
        chk("readA_00", res, 8'h00);

        // random traffic; fields change freely while not accepted
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_src   = 2'($urandom_range(0, 3));
            cmd_dst   = 2'($urandom_range(0, 3));
            cmd_imm   = 8'($urandom);
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && cmd_ready !== 1'b1; c++) @(negedge clk);
        chk("final_idle", cmd_ready, 1);
        @(negedge clk);
        for (int r = 0; r < 3; r++) chk("regfile", g_regs[r], m_regs[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
